// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding, stage index constants and the stall-bus width helper.
package pipe_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FWAIT = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    // Stage indices as seen by REQ_STAGE (stage 0 is the PC register)
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Stall/bubble buses cover the PC plus one register per stage
    function automatic int stall_bus_w(input int nstage);
        return nstage + 1;
    endfunction

endpackage

// File: rtl/pipe_stall_merge.sv
// Combinational stall merge: the deepest requesting stage wins.
// Every register up to and including that stage holds, and the register
// feeding the next stage loads a bubble (unless the stage is the last one).
module pipe_stall_merge
    import pipe_ctrl_pkg::*;
#(
    parameter int                NSTAGE    = 5,
    parameter int                NREQ      = 2,
    parameter logic [4*NREQ-1:0] REQ_STAGE = {4'd3, 4'd2}
) (
    input  logic [NREQ-1:0]                stallreq,
    output logic [stall_bus_w(NSTAGE)-1:0] stall,
    output logic [stall_bus_w(NSTAGE)-1:0] bubble
);

    localparam int SBW = stall_bus_w(NSTAGE);

    // A source mapped to stage 0 or beyond the last stage is a config error
    for (genvar i = 0; i < NREQ; i++) begin : g_chk
        if (REQ_STAGE[4*i +: 4] == 4'd0 || int'(REQ_STAGE[4*i +: 4]) > NSTAGE) begin : g_bad
            $error("pipe_stall_merge: REQ_STAGE for source %0d out of range", i);
        end
    end

    logic [3:0] smax;
    logic       any;

    // Priority-max over asserted requests, then thermometer/one-hot expansion
    always_comb begin
        smax   = '0;
        any    = 1'b0;
        stall  = '0;
        bubble = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stallreq[i]) begin
                any = 1'b1;
                if (REQ_STAGE[4*i +: 4] > smax) smax = REQ_STAGE[4*i +: 4];
            end
        end
        for (int k = 0; k < SBW; k++) begin
            stall[k]  = any && (k <= int'(smax));
            bubble[k] = any && (k == int'(smax)) && (k < NSTAGE);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges per-stage stall requests, sequences
// exception/redirect flushes behind an outstanding instruction fetch, and
// flags pipelines stalled for too long via a sticky watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                NSTAGE    = 5,
    parameter int                NREQ      = 2,
    parameter logic [4*NREQ-1:0] REQ_STAGE = {4'd3, 4'd2},
    parameter int                WDOG_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                stallreq,
    input  logic                           flush_req,
    input  logic [31:0]                    flush_pc,
    input  logic                           if_busy,
    output logic [stall_bus_w(NSTAGE)-1:0] stall,
    output logic [stall_bus_w(NSTAGE)-1:0] bubble,
    output logic [NSTAGE-1:0]              flush,
    output logic                           redirect_valid,
    output logic [31:0]                    redirect_pc,
    output logic                           hang
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]                    perf_stall_cyc,
    output logic [31:0]                    perf_flush_cnt
`endif
);

    localparam int SBW = stall_bus_w(NSTAGE);

    pipe_state_e         state_q;
    logic [31:0]         pc_q;
    logic [NSTAGE-1:0]   flush_q;
    logic                rv_q;
    logic [31:0]         rpc_q;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                hang_q, hang_d;
    logic [SBW-1:0]      m_stall, m_bubble;

    pipe_stall_merge #(
        .NSTAGE    (NSTAGE),
        .NREQ      (NREQ),
        .REQ_STAGE (REQ_STAGE)
    ) u_merge (
        .stallreq (stallreq),
        .stall    (m_stall),
        .bubble   (m_bubble)
    );

    // Stall/bubble source depends on state: merged requests only in RUN
    always_comb begin
        stall  = '0;
        bubble = '0;
        unique case (state_q)
            ST_RUN: begin
                stall  = m_stall;
                bubble = m_bubble;
            end
            ST_FWAIT: stall = '1;
            default:  ;
        endcase
    end

    // Flush FSM; flush/redirect outputs are registered on entry to FLUSH.
    // A flush_req in FLUSH is handled exactly like one in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            flush_q <= '0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else begin
            flush_q <= '0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            unique case (state_q)
                ST_FWAIT: begin
                    // newest redirect target wins while waiting for IF
                    if (flush_req) pc_q <= flush_pc;
                    if (!if_busy) begin
                        state_q <= ST_FLUSH;
                        flush_q <= '1;
                        rv_q    <= 1'b1;
                        rpc_q   <= flush_req ? flush_pc : pc_q;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    if (flush_req) begin
                        pc_q <= flush_pc;
                        if (if_busy) begin
                            state_q <= ST_FWAIT;
                        end else begin
                            state_q <= ST_FLUSH;
                            flush_q <= '1;
                            rv_q    <= 1'b1;
                            rpc_q   <= flush_pc;
                        end
                    end
                end
            endcase
        end
    end

    // Watchdog next state: saturating count of consecutive stalled cycles
    always_comb begin
        wdog_d = '0;
        if (|stall) wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
        hang_d = hang_q | (wdog_d == '1);
    end

    // Watchdog registers; hang is sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            hang_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            hang_q <= hang_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign hang           = hang_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    // Free-running wrap-around counters: PC-hold cycles and FLUSH entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall[0])              perf_stall_q <= perf_stall_q + 32'd1;
            if (state_q == ST_FLUSH)   perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (default stages/sources, WDOG_W=4).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stallreq;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        if_busy;
    logic [5:0]  stall, bubble;
    logic [4:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hang;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGE(5), .NREQ(2), .REQ_STAGE({4'd3, 4'd2}), .WDOG_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq       (stallreq),
        .flush_req      (flush_req),
        .flush_pc       (flush_pc),
        .if_busy        (if_busy),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hang           (hang)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".stall"},  64'(stall),          64'h0);
        chk({tag, ".bubble"}, 64'(bubble),         64'h0);
        chk({tag, ".flush"},  64'(flush),          64'h0);
        chk({tag, ".rv"},     64'(redirect_valid), 64'h0);
        chk({tag, ".rpc"},    64'(redirect_pc),    64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; stallreq = '0; flush_req = 1'b0; flush_pc = '0; if_busy = 1'b0;
        tick();
        #1;
        chk_idle("rst");
        chk("rst.hang", 64'(hang), 64'h0);
        rst = 1'b1;
        tick();

        // T1: ID request held 3 cycles
        for (int c = 0; c < 3; c++) begin
            stallreq = 2'b01; #1;
            chk("t1.stall",  64'(stall),  64'h07);
            chk("t1.bubble", 64'(bubble), 64'h04);
            tick();
        end
        stallreq = 2'b00; #1;
        chk("t1.rel.stall",  64'(stall),  64'h00);
        chk("t1.rel.bubble", 64'(bubble), 64'h00);
        tick();

        // T2: EX alone, then both (EX wins)
        stallreq = 2'b10; #1;
        chk("t2.ex.stall",  64'(stall),  64'h0F);
        chk("t2.ex.bubble", 64'(bubble), 64'h08);
        tick();
        stallreq = 2'b11; #1;
        chk("t2.both.stall",  64'(stall),  64'h0F);
        chk("t2.both.bubble", 64'(bubble), 64'h08);
        tick();

        // T3: immediate flush; stall still follows merge in the request cycle
        stallreq = 2'b01; flush_req = 1'b1; flush_pc = 32'hBFC0_0380; if_busy = 1'b0; #1;
        chk("t3.req.stall", 64'(stall), 64'h07);
        chk("t3.req.rv",    64'(redirect_valid), 64'h0);
        tick();
        flush_req = 1'b0; flush_pc = '0; #1;
        chk("t3.fl.flush",  64'(flush),          64'h1F);
        chk("t3.fl.rv",     64'(redirect_valid), 64'h1);
        chk("t3.fl.rpc",    64'(redirect_pc),    64'hBFC0_0380);
        chk("t3.fl.stall",  64'(stall),          64'h00);
        chk("t3.fl.bubble", 64'(bubble),         64'h00);
        tick();
        stallreq = 2'b00; #1;
        chk_idle("t3.after");
        tick();

        // T4: flush behind a busy fetch, newest target wins
        flush_req = 1'b1; flush_pc = 32'h100; if_busy = 1'b1; #1;
        chk("t4.c0.stall", 64'(stall), 64'h00);
        tick();
        flush_req = 1'b0; stallreq = 2'b10; #1;
        chk("t4.c1.stall",  64'(stall),  64'h3F);
        chk("t4.c1.bubble", 64'(bubble), 64'h00);
        chk("t4.c1.rv",     64'(redirect_valid), 64'h0);
        tick();
        stallreq = 2'b00; flush_req = 1'b1; flush_pc = 32'h200; #1;
        chk("t4.c2.stall", 64'(stall), 64'h3F);
        tick();
        flush_req = 1'b0; flush_pc = '0; if_busy = 1'b0; #1;
        chk("t4.c3.stall", 64'(stall), 64'h3F);
        chk("t4.c3.rv",    64'(redirect_valid), 64'h0);
        tick();
        #1;
        chk("t4.c4.rv",    64'(redirect_valid), 64'h1);
        chk("t4.c4.rpc",   64'(redirect_pc),    64'h200);
        chk("t4.c4.flush", 64'(flush),          64'h1F);
        chk("t4.c4.stall", 64'(stall),          64'h00);
        tick();
        #1;
        chk_idle("t4.c5");
        chk("t4.hang", 64'(hang), 64'h0);

        // T5: watchdog with WDOG_W=4 saturates after 15 stalled cycles
        do_reset();
        for (int c = 0; c < 20; c++) begin
            stallreq = 2'b01; #1;
            chk($sformatf("t5.hang%0d", c), 64'(hang), (c >= 15) ? 64'h1 : 64'h0);
            tick();
        end
        stallreq = 2'b00; #1;
        chk("t5.rel.hang", 64'(hang), 64'h1);
        tick(); tick(); #1;
        chk("t5.sticky.hang", 64'(hang), 64'h1);
        do_reset();
        #1;
        chk("t5.rst.hang", 64'(hang), 64'h0);

        // T6: reset during FWAIT drops the pending redirect
        flush_req = 1'b1; flush_pc = 32'h300; if_busy = 1'b1; #1;
        tick();
        flush_req = 1'b0; #1;
        chk("t6.fwait.stall", 64'(stall), 64'h3F);
        rst = 1'b0; if_busy = 1'b0; #1;
        chk("t6.inrst.stall", 64'(stall), 64'h00);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk($sformatf("t6.rv%0d", c), 64'(redirect_valid), 64'h0);
        end
        stallreq = 2'b01; #1;
        chk("t6.run.stall", 64'(stall), 64'h07);
`ifdef PIPE_CTRL_PERF_EN
        chk("t6.perf_flush", 64'(perf_flush_cnt), 64'h0);
`endif
        stallreq = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // hard time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
